// File: rtl/bin_stream_loader.sv
// Streams clause/var-bin words into bin_manager RAMs, launches bin_manager and collects its result.
// Write lands one cycle after each accepted beat; s_ready_o is high only while loading.
module bin_stream_loader #(
  parameter int NUM_CLAUSES_A_BIN = 8,
  parameter int WIDTH_CLAUSES     = 16,
  parameter int WIDTH_VAR         = 12,
  parameter int ADDR_WIDTH        = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_en_i,
  input  logic [WIDTH_CLAUSES-1:0] cfg_nb_i,
  input  logic [WIDTH_VAR-1:0]     cfg_nv_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  input  logic [WIDTH_CLAUSES-1:0] s_clause_i,
  input  logic [WIDTH_VAR-1:0]     s_var_i,
  output logic                     apply_ex_o,
  output logic                     ram_we_c_ex_o,
  output logic [WIDTH_CLAUSES-1:0] ram_din_c_ex_o,
  output logic [ADDR_WIDTH-1:0]    ram_addr_c_ex_o,
  output logic                     ram_we_v_ex_o,
  output logic [WIDTH_VAR-1:0]     ram_din_v_ex_o,
  output logic [ADDR_WIDTH-1:0]    ram_addr_v_ex_o,
  output logic                     start_bm_o,
  output logic                     bin_info_en_o,
  output logic [WIDTH_CLAUSES-1:0] nb_all_o,
  output logic [WIDTH_VAR-1:0]     nv_all_o,
  input  logic                     done_bm_i,
  input  logic                     global_sat_i,
  input  logic                     global_unsat_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     sat_o,
  output logic                     unsat_o,
  output logic                     cfg_err_o
);

  localparam int CW = ADDR_WIDTH + 1;
  // Product is kept wide enough that oversize bin counts cannot wrap past the range check.
  localparam int PW = WIDTH_CLAUSES + $clog2(NUM_CLAUSES_A_BIN) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, GAP, LAUNCH, WAIT_BM} state_t;

  state_t          state;
  logic [CW-1:0]   total;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   prod;
  logic            cfg_bad;

  always_comb begin
    prod    = PW'(cfg_nb_i) * PW'(NUM_CLAUSES_A_BIN);
    cfg_bad = (cfg_nb_i == '0) || (prod > PW'((2 ** ADDR_WIDTH) - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      total           <= '0;
      cnt             <= '0;
      s_ready_o       <= 1'b0;
      apply_ex_o      <= 1'b0;
      ram_we_c_ex_o   <= 1'b0;
      ram_din_c_ex_o  <= '0;
      ram_addr_c_ex_o <= '0;
      ram_we_v_ex_o   <= 1'b0;
      ram_din_v_ex_o  <= '0;
      ram_addr_v_ex_o <= '0;
      start_bm_o      <= 1'b0;
      bin_info_en_o   <= 1'b0;
      nb_all_o        <= '0;
      nv_all_o        <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      sat_o           <= 1'b0;
      unsat_o         <= 1'b0;
      cfg_err_o       <= 1'b0;
    end else begin
      done_o        <= 1'b0;
      cfg_err_o     <= 1'b0;
      ram_we_c_ex_o <= 1'b0;
      ram_we_v_ex_o <= 1'b0;
      start_bm_o    <= 1'b0;
      bin_info_en_o <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_en_i) begin
            nb_all_o <= cfg_nb_i;
            nv_all_o <= cfg_nv_i;
            total    <= prod[CW-1:0];
            cnt      <= '0;
            sat_o    <= 1'b0;
            unsat_o  <= 1'b0;
            if (cfg_bad) begin
              cfg_err_o <= 1'b1;
            end else begin
              state      <= LOAD;
              busy_o     <= 1'b1;
              apply_ex_o <= 1'b1;
              s_ready_o  <= 1'b1;
            end
          end
        end

        LOAD: begin
          // Address 0 is reserved by bin_manager, so beat n lands at n+1.
          if (s_valid_i && s_ready_o) begin
            ram_we_c_ex_o   <= 1'b1;
            ram_we_v_ex_o   <= 1'b1;
            ram_addr_c_ex_o <= ADDR_WIDTH'(cnt + CW'(1));
            ram_addr_v_ex_o <= ADDR_WIDTH'(cnt + CW'(1));
            ram_din_c_ex_o  <= s_clause_i;
            ram_din_v_ex_o  <= s_var_i;
            cnt             <= cnt + CW'(1);
            if (cnt == total - CW'(1)) begin
              state     <= GAP;
              s_ready_o <= 1'b0;
            end
          end
        end

        GAP: begin
          apply_ex_o    <= 1'b0;
          start_bm_o    <= 1'b1;
          bin_info_en_o <= 1'b1;
          state         <= LAUNCH;
        end

        LAUNCH: begin
          state <= WAIT_BM;
        end

        WAIT_BM: begin
          if (done_bm_i) begin
            sat_o   <= global_sat_i;
            unsat_o <= global_unsat_i;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_stream_loader.sv
// Directed bench for bin_stream_loader: normal load, throttled load, config errors, reset mid-load.
module tb_bin_stream_loader;

  localparam int NCB = 8;
  localparam int WC  = 16;
  localparam int WV  = 12;
  localparam int AW  = 9;

  logic          clk;
  logic          rst;
  logic          cfg_en_i;
  logic [WC-1:0] cfg_nb_i;
  logic [WV-1:0] cfg_nv_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [WC-1:0] s_clause_i;
  logic [WV-1:0] s_var_i;
  logic          apply_ex_o;
  logic          ram_we_c_ex_o;
  logic [WC-1:0] ram_din_c_ex_o;
  logic [AW-1:0] ram_addr_c_ex_o;
  logic          ram_we_v_ex_o;
  logic [WV-1:0] ram_din_v_ex_o;
  logic [AW-1:0] ram_addr_v_ex_o;
  logic          start_bm_o;
  logic          bin_info_en_o;
  logic [WC-1:0] nb_all_o;
  logic [WV-1:0] nv_all_o;
  logic          done_bm_i;
  logic          global_sat_i;
  logic          global_unsat_i;
  logic          busy_o;
  logic          done_o;
  logic          sat_o;
  logic          unsat_o;
  logic          cfg_err_o;

  bin_stream_loader #(
    .NUM_CLAUSES_A_BIN(NCB), .WIDTH_CLAUSES(WC), .WIDTH_VAR(WV), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_en_i(cfg_en_i), .cfg_nb_i(cfg_nb_i), .cfg_nv_i(cfg_nv_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_clause_i(s_clause_i), .s_var_i(s_var_i),
    .apply_ex_o(apply_ex_o),
    .ram_we_c_ex_o(ram_we_c_ex_o), .ram_din_c_ex_o(ram_din_c_ex_o), .ram_addr_c_ex_o(ram_addr_c_ex_o),
    .ram_we_v_ex_o(ram_we_v_ex_o), .ram_din_v_ex_o(ram_din_v_ex_o), .ram_addr_v_ex_o(ram_addr_v_ex_o),
    .start_bm_o(start_bm_o), .bin_info_en_o(bin_info_en_o),
    .nb_all_o(nb_all_o), .nv_all_o(nv_all_o),
    .done_bm_i(done_bm_i), .global_sat_i(global_sat_i), .global_unsat_i(global_unsat_i),
    .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o), .cfg_err_o(cfg_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int wr_addr[$];
  int wr_c[$];
  int wr_v[$];
  int wr_cyc[$];
  int n_start = 0;
  int n_done = 0;
  int n_skew = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ram_we_c_ex_o) begin
      wr_addr.push_back(int'(ram_addr_c_ex_o));
      wr_c.push_back(int'(ram_din_c_ex_o));
      wr_v.push_back(int'(ram_din_v_ex_o));
      wr_cyc.push_back(cyc);
    end
    if (ram_we_c_ex_o !== ram_we_v_ex_o || (ram_we_c_ex_o && ram_addr_c_ex_o !== ram_addr_v_ex_o))
      n_skew++;
    if (start_bm_o) n_start++;
    if (done_o) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int nb, input int nv);
    cfg_en_i = 1'b1;
    cfg_nb_i = WC'(nb);
    cfg_nv_i = WV'(nv);
    tick();
    cfg_en_i = 1'b0;
  endtask

  initial begin
    int base;
    int k;
    int s0;
    int w0;

    rst = 1'b0; cfg_en_i = 1'b0; cfg_nb_i = '0; cfg_nv_i = '0;
    s_valid_i = 1'b0; s_clause_i = '0; s_var_i = '0;
    done_bm_i = 1'b0; global_sat_i = 1'b0; global_unsat_i = 1'b0;
    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", s_ready_o, 0);
    chk("rst_apply", apply_ex_o, 0);
    chk("rst_we", ram_we_c_ex_o, 0);
    chk("rst_start", start_bm_o, 0);
    chk("rst_nb_all", nb_all_o, 0);
    rst = 1'b1;
    tick();

    // nb=2 nv=5, 16 back-to-back beats
    cfg(2, 5);
    chk("t1_ready", s_ready_o, 1);
    chk("t1_apply", apply_ex_o, 1);
    chk("t1_busy", busy_o, 1);
    base = wr_addr.size();
    for (int i = 0; i < 16; i++) begin
      s_valid_i = 1'b1; s_clause_i = WC'(i); s_var_i = WV'(i + 100);
      tick();
    end
    s_valid_i = 1'b0;
    chk("t1_ready_low", s_ready_o, 0);
    chk("t1_last_we", ram_we_c_ex_o, 1);
    chk("t1_last_addr", ram_addr_c_ex_o, 16);
    chk("t1_apply_last", apply_ex_o, 1);
    tick();
    chk("t1_apply_drop", apply_ex_o, 0);
    chk("t1_we_drop", ram_we_c_ex_o, 0);
    chk("t1_start", start_bm_o, 1);
    chk("t1_info_en", bin_info_en_o, 1);
    chk("t1_nb_all", nb_all_o, 2);
    chk("t1_nv_all", nv_all_o, 5);
    tick();
    chk("t1_start_off", start_bm_o, 0);
    chk("t1_start_cnt", n_start, 1);
    chk("t1_wr_cnt", wr_addr.size() - base, 16);
    for (int i = 0; i < 16 && base + i < wr_addr.size(); i++) begin
      chk("t1_addr", wr_addr[base + i], i + 1);
      chk("t1_din_c", wr_c[base + i], i);
      chk("t1_din_v", wr_v[base + i], i + 100);
      chk("t1_consec", wr_cyc[base + i] - wr_cyc[base], i);
    end

    // bin_manager reports unsat
    done_bm_i = 1'b1; global_unsat_i = 1'b1; global_sat_i = 1'b0;
    tick();
    done_bm_i = 1'b0; global_unsat_i = 1'b0;
    chk("t1_done", done_o, 1);
    chk("t1_unsat", unsat_o, 1);
    chk("t1_sat", sat_o, 0);
    chk("t1_busy_off", busy_o, 0);
    tick();
    chk("t1_done_pulse", done_o, 0);
    chk("t1_unsat_hold", unsat_o, 1);

    // nb=1, valid every other cycle; stray done/cfg_en during LOAD
    cfg(1, 3);
    chk("t2_unsat_clr", unsat_o, 0);
    s0 = n_done;
    base = wr_addr.size();
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      done_bm_i = 1'b1;
      cfg_en_i = 1'b1; cfg_nb_i = WC'(5);
      s_valid_i = (c % 2 == 0);
      if (s_valid_i && s_ready_o) begin
        s_clause_i = WC'(16'h50 + k); s_var_i = WV'(12'h20 + k);
        k++;
      end else begin
        s_clause_i = 16'hDEAD; s_var_i = 12'hBAD;
      end
      tick();
    end
    s_valid_i = 1'b0; done_bm_i = 1'b0; cfg_en_i = 1'b0;
    chk("t2_beats_sent", k, 8);
    tick();
    chk("t2_start", start_bm_o, 1);
    chk("t2_nb_all", nb_all_o, 1);
    chk("t2_nv_all", nv_all_o, 3);
    tick(); tick();
    chk("t2_early_done", n_done - s0, 0);
    chk("t2_busy", busy_o, 1);
    chk("t2_wr_cnt", wr_addr.size() - base, 8);
    for (int i = 0; i < 8 && base + i < wr_addr.size(); i++) begin
      chk("t2_addr", wr_addr[base + i], i + 1);
      chk("t2_din_c", wr_c[base + i], 16'h50 + i);
      chk("t2_din_v", wr_v[base + i], 12'h20 + i);
    end
    done_bm_i = 1'b1; global_sat_i = 1'b1;
    tick();
    done_bm_i = 1'b0; global_sat_i = 1'b0;
    chk("t2_done", done_o, 1);
    chk("t2_sat", sat_o, 1);
    chk("t2_unsat", unsat_o, 0);
    tick();

    // nb=0 and nb=64 rejected
    s0 = n_start;
    w0 = wr_addr.size();
    cfg(0, 4);
    chk("t3_err0", cfg_err_o, 1);
    chk("t3_busy0", busy_o, 0);
    chk("t3_ready0", s_ready_o, 0);
    tick();
    chk("t3_err0_pulse", cfg_err_o, 0);
    chk("t3_busy0_b", busy_o, 0);
    cfg(64, 4);
    chk("t3_err64", cfg_err_o, 1);
    chk("t3_busy64", busy_o, 0);
    tick();
    chk("t3_err64_pulse", cfg_err_o, 0);
    chk("t3_apply64", apply_ex_o, 0);
    chk("t3_no_start", n_start - s0, 0);
    chk("t3_no_write", wr_addr.size() - w0, 0);

    // nb=63 fills addresses 1..504
    cfg(63, 7);
    chk("t3_err63", cfg_err_o, 0);
    chk("t3_busy63", busy_o, 1);
    base = wr_addr.size();
    for (int i = 0; i < 504; i++) begin
      s_valid_i = 1'b1; s_clause_i = WC'(i); s_var_i = WV'(i);
      tick();
    end
    s_valid_i = 1'b0;
    chk("t3_last_addr", ram_addr_c_ex_o, 504);
    tick(); tick();
    chk("t3_wr_cnt", wr_addr.size() - base, 504);
    chk("t3_start", n_start - s0, 1);
    done_bm_i = 1'b1;
    tick();
    done_bm_i = 1'b0;
    chk("t3_done", done_o, 1);
    tick();

    // reset after beat 5 of 16
    cfg(2, 5);
    base = wr_addr.size();
    for (int i = 0; i < 5; i++) begin
      s_valid_i = 1'b1; s_clause_i = WC'(16'h70 + i); s_var_i = WV'(i);
      tick();
    end
    s_clause_i = 16'h75; rst = 1'b0;
    tick();
    chk("t4_we_c", ram_we_c_ex_o, 0);
    chk("t4_we_v", ram_we_v_ex_o, 0);
    chk("t4_apply", apply_ex_o, 0);
    chk("t4_ready", s_ready_o, 0);
    chk("t4_busy", busy_o, 0);
    chk("t4_nb_all", nb_all_o, 0);
    chk("t4_nv_all", nv_all_o, 0);
    chk("t4_addr", ram_addr_c_ex_o, 0);
    chk("t4_wr_cnt", wr_addr.size() - base, 5);
    rst = 1'b1; s_valid_i = 1'b0;
    tick();
    cfg(1, 1);
    s_valid_i = 1'b1; s_clause_i = 16'hAAAA; s_var_i = 12'h555;
    tick();
    s_valid_i = 1'b0;
    chk("t4_restart_we", ram_we_c_ex_o, 1);
    chk("t4_restart_addr", ram_addr_c_ex_o, 1);
    chk("t4_restart_din", ram_din_c_ex_o, 16'hAAAA);
    chk("we_skew", n_skew, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
